// File: rtl/diff_order_level_calculator.sv
// Converts a differential order N into a nominal channel level L = L0 * TOE^N (mV).
// Optional macro LEVEL_CALC_ROUND_EN: round half-up instead of truncating.
module diff_order_level_calculator #(
  parameter logic [31:0] L0_Q16  = 32'd63161827,
  parameter logic [15:0] TOE_Q16 = 16'd30779
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] N,
  output logic        busy,
  output logic        done,
  output logic [11:0] L_mV
);

`ifdef LEVEL_CALC_ROUND_EN
  localparam logic [47:0] STEP_RND = 48'd32768;
  localparam logic [32:0] OUT_RND  = 33'd32768;
`else
  localparam logic [47:0] STEP_RND = 48'd0;
  localparam logic [32:0] OUT_RND  = 33'd0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, MUL, OUT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [31:0] acc_reg, acc_next;
  logic [11:0] level_reg, level_next;
  logic        done_reg, done_next;

  logic [31:0] step_acc;
  logic [16:0] level_int;

  // Single-cycle Q16 multiply; TOE < 1 so the result always fits back in 32 bits.
  assign step_acc  = 32'((({16'd0, acc_reg} * {32'd0, TOE_Q16}) + STEP_RND) >> 16);
  assign level_int = 17'(({1'b0, acc_reg} + OUT_RND) >> 16);

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign L_mV = level_reg;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      acc_reg   <= 32'd0;
      level_reg <= 12'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      level_reg <= level_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    level_next = level_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next   = N;
          state_next = LOAD;
        end
      end
      LOAD: begin
        acc_next   = L0_Q16;
        state_next = MUL;
      end
      MUL: begin
        // Below 2^15 every further step is zero, so stop early; the output stage then yields 0.
        if (cnt_reg == 16'd0 || acc_reg < 32'd32768) begin
          state_next = OUT;
        end else begin
          acc_next = step_acc;
          cnt_next = cnt_reg - 16'd1;
        end
      end
      OUT: begin
        level_next = (level_int > 17'd4095) ? 12'd4095 : level_int[11:0];
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_diff_order_level_calculator.sv
// Randomized scoreboard bench for diff_order_level_calculator; honours LEVEL_CALC_ROUND_EN.
module tb_diff_order_level_calculator;

  localparam longint unsigned L0  = 64'd63161827;
  localparam longint unsigned TOE = 64'd30779;
`ifdef LEVEL_CALC_ROUND_EN
  localparam longint unsigned RND = 64'd32768;
`else
  localparam longint unsigned RND = 64'd0;
`endif

  logic        clk_50 = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic [15:0] N      = 16'd0;
  logic        busy;
  logic        done;
  logic [11:0] L_mV;

  typedef struct {
    int lv;
    int k;
    int done_cyc;
  } sb_t;

  sb_t sb[$];
  int  cyc         = 0;
  int  vectors     = 0;
  int  miscompares = 0;
  int  last_lat    = 0;

  diff_order_level_calculator dut (
    .clk_50(clk_50),
    .reset (reset),
    .start (start),
    .N     (N),
    .busy  (busy),
    .done  (done),
    .L_mV  (L_mV)
  );

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Level = L0 * TOE^n in Q16, one ratio per order, stopping once the level is below half an LSB.
  function automatic void model(input int n, output int lv, output int m);
    longint unsigned acc;
    longint unsigned res;
    int left;
    acc  = L0;
    left = n;
    m    = 0;
    while (left > 0 && acc >= 64'd32768) begin
      acc = (acc * TOE + RND) / 64'd65536;
      left--;
      m++;
    end
    res = (acc + RND) / 64'd65536;
    lv  = (res > 64'd4095) ? 4095 : int'(res);
  endfunction

  // Monitor: per-cycle busy expectation plus scoreboard pop on done.
  always @(negedge clk_50) begin
    if (!reset) begin
      sb_t e;
      bit  exp_busy;
      exp_busy = (sb.size() > 0) && (cyc < sb[0].done_cyc);
      check("busy", int'(busy), int'(exp_busy));
      if (done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 with L_mV=%0d, expected no done (cycle %0d)", L_mV, cyc);
        end else begin
          e = sb.pop_front();
          last_lat = cyc - e.k;
          check("L_mV", int'(L_mV), e.lv);
          check("latency", cyc - e.k, e.done_cyc - e.k);
          $display("txn: accept@%0d done@%0d L_mV=%0d exp=%0d", e.k, cyc, L_mV, e.lv);
        end
      end
    end
  end

  task automatic issue(input int n, input bit junk, input int junk_n);
    sb_t e;
    int  lv, m;
    @(posedge clk_50); #1;
    start = 1'b1;
    N     = 16'(n);
    @(posedge clk_50); #1;
    start = 1'b0;
    N     = 16'($urandom);
    model(n, lv, m);
    e.lv       = lv;
    e.k        = cyc;
    e.done_cyc = cyc + 3 + m;
    sb.push_back(e);
    if (junk) begin
      @(posedge clk_50); #1;
      start = 1'b1;
      N     = 16'(junk_n);
      @(posedge clk_50); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk_50); #1;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got no done within 40 cycles, expected done (cycle %0d)", cyc);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk_50);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk_50);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_L_mV", int'(L_mV), 0);

    issue(0, 1'b0, 0);
    wait_done();
`ifdef LEVEL_CALC_ROUND_EN
    check("n0_value", int'(L_mV), 964);
`else
    check("n0_value", int'(L_mV), 963);
`endif
    check("n0_latency", last_lat, 3);

    issue(1, 1'b0, 0);
    wait_done();
`ifdef LEVEL_CALC_ROUND_EN
    check("n1_value", int'(L_mV), 453);
`else
    check("n1_value", int'(L_mV), 452);
`endif
    check("n1_latency", last_lat, 4);

    issue(2, 1'b0, 0);
    wait_done();
`ifdef LEVEL_CALC_ROUND_EN
    check("n2_value", int'(L_mV), 213);
`endif
    check("n2_latency", last_lat, 5);

    issue(65535, 1'b0, 0);
    wait_done();
    check("early_exit_value", int'(L_mV), 0);
    check("early_exit_le14", int'(last_lat <= 14), 1);

    // Restart attempt with a different N while busy must be ignored.
    issue(3, 1'b1, 0);
    wait_done();
`ifdef LEVEL_CALC_ROUND_EN
    check("repulse_value", int'(L_mV), 100);
`endif
    repeat (6) @(posedge clk_50);
    #1;

    // Reset in MUL discards the computation.
    issue(5, 1'b0, 0);
    repeat (2) @(posedge clk_50);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk_50); #1;
    reset = 1'b0;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_L_mV", int'(L_mV), 0);
    repeat (10) @(posedge clk_50);
    #1;
    issue(1, 1'b0, 0);
    wait_done();
`ifdef LEVEL_CALC_ROUND_EN
    check("post_reset_n1", int'(L_mV), 453);
`else
    check("post_reset_n1", int'(L_mV), 452);
`endif

    for (int i = 0; i < 30; i++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 14));
      issue(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)));
      wait_done();
      repeat ($urandom_range(0, 3)) @(posedge clk_50);
    end

    repeat (4) @(posedge clk_50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/diff_order_level_calculator.md
# diff_order_level_calculator

Inverse of the differential-order calculator. Takes a differential order N and computes the nominal channel level L_mV = L0 · TOE^N, where L0 = 963.773 mV and TOE = 0.46965. The result is a 12-bit millivolt value. The block sits beside the order calculator on the clk_50 domain and feeds the threshold/DAC path, so software can ask "what level does order N correspond to".

## Interface
- L0_Q16, default 63161827: level at N = 0, in mV, unsigned Q16.16.
- TOE_Q16, default 30779: per-order ratio, unsigned Q0.16. Must be < 65536.
- clk_50  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE.
- N  in  16  order to convert. Captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; L_mV valid from this cycle.
- L_mV  out  12  result in mV. Held until the next done or reset.

## Operation
- States: IDLE, LOAD, MUL, OUT.
- IDLE
  - start=1 → capture N into cnt, go to LOAD.
  - start=0 → stay in IDLE.
- LOAD: acc (32 b) <= L0_Q16, go to MUL.
- MUL: one step per cycle.
  - If cnt == 0 or acc < 2^15 → go to OUT.
  - Otherwise: acc <= (acc·TOE_Q16 [+ 2^15]) >> 16, then cnt <= cnt − 1. The +2^15 term applies only with rounding enabled (see Configuration).
  - Product is 48 bits. acc never grows, because TOE < 1.
- OUT
  - L_mV <= (acc [+ 2^15]) >> 16, saturated to 4095.
  - Pulse done, go to IDLE.
- Early exit: once acc < 2^15, every further step yields 0. The result is forced to 0 and the remaining steps are skipped.
- start while busy: ignored; it is neither queued nor restarts the computation.
- N changing while busy: no effect; N was captured on the accepted start.
- reset in any state: state <= IDLE. L_mV, busy and done are cleared. Any in-flight computation is discarded.
- Reset values: busy=0, done=0, L_mV=0.

## Timing
- start accepted at posedge k.
- busy is high for cycles k+1 … k+2+M, where M is the number of multiply steps actually performed: M = N, or fewer on early exit.
- done and the new L_mV appear at posedge k+3+M.
- N=0: done at k+3.
- Worst case M ≤ 11 with default constants, so done is never later than k+14.
- Back-to-back: a start sampled in the cycle done is high is ignored, because the FSM is in OUT. The earliest new accept is the cycle after done.
- The multiplier is single-cycle combinational. No pipeline registers are inside MUL.

## Configuration
- LEVEL_CALC_ROUND_EN defined: round half-up at every multiply step and at the final Q16 → integer conversion.
- LEVEL_CALC_ROUND_EN undefined: truncate at both points.
  - Results are ≤ the rounded values.
  - Latency rules are unchanged, including the early-exit threshold acc < 2^15.
- Test values below assume LEVEL_CALC_ROUND_EN is defined unless noted.

## Test plan
- Reset, then idle 5 cycles → busy=0, done=0, L_mV=0.
- start with N=0 at cycle k → done only at k+3; L_mV=964. Without the macro: L_mV=963.
- start with N=1, then N=2, each after the previous done → L_mV=453 with done at k+4, then L_mV=213 with done at k+5. Without the macro: 452 for N=1.
- start with N=0xFFFF → early exit; done at or before k+14; L_mV=0; busy drops the same cycle done rises.
- N=3, with start re-pulsed and N changed to 0 two cycles in → single done; result equals the N=3 value (100); no second done.
- N=5, with reset asserted in MUL → the next cycle has busy=0, L_mV=0, and no done. A fresh start with N=1 then gives 453.
